// File: rtl/fsic_io_serdes_tx_sched.sv
// Serdes TX scheduler: link training, credit-gated round-robin arbitration with
// requester 2 priority. Optional macro FSIC_TX_PARITY_EN puts even parity in bit 15.
module fsic_io_serdes_tx_sched #(
    parameter int unsigned pTRAIN_CYCLES = 16,
    parameter int unsigned pCREDIT_MAX   = 8
) (
    input  logic        coreclk,
    input  logic        axis_rst,
    input  logic        retrain,
    input  logic [2:0]  src_valid,
    input  logic [35:0] src_data,
    output logic [2:0]  src_ready,
    input  logic        credit_return,
    output logic [15:0] txdata_out,
    output logic        tx_link_up,
    output logic [3:0]  credit_cnt
);

    typedef enum logic [1:0] {StIdle, StTrain, StActive} state_e;

    localparam logic [7:0]  TrainLast = 8'(pTRAIN_CYCLES - 1);
    localparam logic [3:0]  CreditMax = 4'(pCREDIT_MAX);
    localparam logic [15:0] TrainWord = 16'hA5A5;

    state_e      state_q, state_d;
    logic [7:0]  train_cnt_q, train_cnt_d;
    logic [3:0]  credit_q, credit_d;
    logic [1:0]  rr_q, rr_d;
    logic [15:0] tx_q, tx_d;
    logic        up_q, up_d;

    logic        gnt_vld;
    logic [1:0]  gnt_idx;
    logic [1:0]  cand;
    logic [11:0] payload;
    logic [15:0] data_word;

    // Requester 2 overrides the rotation; otherwise scan from rr_q, nearest wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        if (state_q == StActive && credit_q != 4'd0 && !retrain) begin
            if (src_valid[2]) begin
                gnt_vld = 1'b1;
                gnt_idx = 2'd2;
            end else begin
                for (int k = 2; k >= 0; k--) begin
                    cand = 2'((32'(rr_q) + 32'(k)) % 32'd3);
                    if (src_valid[cand]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
    end

    assign src_ready = gnt_vld ? (3'b001 << gnt_idx) : 3'b000;
    assign payload   = src_data[32'(gnt_idx) * 12 +: 12];

    always_comb begin
        data_word[14:0] = {gnt_idx + 2'd1, 1'b0, payload};
`ifdef FSIC_TX_PARITY_EN
        data_word[15] = ^data_word[14:0];
`else
        data_word[15] = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        credit_d    = credit_q;
        rr_d        = rr_q;
        tx_d        = 16'h0000;
        if (retrain || state_q == StIdle) begin
            state_d     = StTrain;
            train_cnt_d = 8'd0;
            credit_d    = 4'd0;
            tx_d        = TrainWord;
        end else if (state_q == StTrain) begin
            if (train_cnt_q == TrainLast) begin
                state_d     = StActive;
                train_cnt_d = 8'd0;
                credit_d    = CreditMax;
            end else begin
                train_cnt_d = train_cnt_q + 8'd1;
                tx_d        = TrainWord;
            end
        end else begin
            if (gnt_vld) begin
                tx_d = data_word;
                rr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            end
            // A simultaneous grant and return cancel; returns at the cap are dropped.
            if (gnt_vld && !credit_return) begin
                credit_d = credit_q - 4'd1;
            end else if (!gnt_vld && credit_return && credit_q < CreditMax) begin
                credit_d = credit_q + 4'd1;
            end
        end
        up_d = (state_d == StActive);
    end

    always_ff @(posedge coreclk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q     <= StIdle;
            train_cnt_q <= 8'd0;
            credit_q    <= 4'd0;
            rr_q        <= 2'd0;
            tx_q        <= 16'h0000;
            up_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            credit_q    <= credit_d;
            rr_q        <= rr_d;
            tx_q        <= tx_d;
            up_q        <= up_d;
        end
    end

    assign txdata_out = tx_q;
    assign tx_link_up = up_q;
    assign credit_cnt = credit_q;

endmodule

// File: tb/tb_fsic_io_serdes_tx_sched.sv
// Bench for fsic_io_serdes_tx_sched: directed scenarios plus randomized traffic,
// every cycle checked against a behavioural model.
module tb_fsic_io_serdes_tx_sched;

    localparam int TRAIN = 16;
    localparam int CMAX  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        retrain = 1'b0;
    logic [2:0]  src_valid = 3'b000;
    logic [35:0] src_data = 36'h0;
    logic [2:0]  src_ready;
    logic        credit_return = 1'b0;
    logic [15:0] txdata_out;
    logic        tx_link_up;
    logic [3:0]  credit_cnt;

    int n_vec = 0;
    int n_err = 0;

    fsic_io_serdes_tx_sched #(
        .pTRAIN_CYCLES(TRAIN),
        .pCREDIT_MAX  (CMAX)
    ) dut (
        .coreclk      (clk),
        .axis_rst     (rst),
        .retrain      (retrain),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .credit_return(credit_return),
        .txdata_out   (txdata_out),
        .tx_link_up   (tx_link_up),
        .credit_cnt   (credit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] mk_word(input int idx, input logic [11:0] pl);
        logic [15:0] w;
        w = 16'(((idx + 1) << 13) | int'(pl));
`ifdef FSIC_TX_PARITY_EN
        if ($countones(w[14:0]) % 2 == 1) w = w | 16'h8000;
`endif
        return w;
    endfunction

    // Behavioural model: mode 0 idle, 1 training, 2 active.
    int          m_mode = 0;
    int          m_left = 0;
    int          m_credit = 0;
    int          m_rr = 0;
    logic [15:0] m_tx = 16'h0;

    always @(negedge clk) begin
        int win;
        int c;
        if (rst) begin
            chk("rst_tx", 32'(txdata_out), 32'h0);
            chk("rst_up", 32'(tx_link_up), 32'h0);
            chk("rst_credit", 32'(credit_cnt), 32'h0);
            chk("rst_ready", 32'(src_ready), 32'h0);
            m_mode = 0; m_left = 0; m_credit = 0; m_rr = 0; m_tx = 16'h0;
        end else begin
            win = -1;
            if (m_mode == 2 && m_credit > 0 && !retrain) begin
                if (src_valid[2]) win = 2;
                else begin
                    for (int k = 0; k < 3; k++) begin
                        c = (m_rr + k) % 3;
                        if (win < 0 && src_valid[c]) win = c;
                    end
                end
            end
            chk("ready", 32'(src_ready), (win < 0) ? 32'h0 : (32'h1 << win));
            chk("txdata", 32'(txdata_out), 32'(m_tx));
            chk("link_up", 32'(tx_link_up), (m_mode == 2) ? 32'h1 : 32'h0);
            chk("credit", 32'(credit_cnt), 32'(m_credit));
            if (retrain || m_mode == 0) begin
                m_mode = 1; m_left = TRAIN; m_credit = 0; m_tx = 16'hA5A5;
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2; m_credit = CMAX; m_tx = 16'h0;
                end else m_tx = 16'hA5A5;
            end else begin
                m_tx = 16'h0;
                if (win >= 0) begin
                    m_tx = mk_word(win, src_data[win*12 +: 12]);
                    m_rr = (win + 1) % 3;
                    m_credit--;
                end
                if (credit_return) m_credit++;
                if (m_credit > CMAX) m_credit = CMAX;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive training words; credit must stay zero throughout.
    task automatic count_train(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (txdata_out != 16'hA5A5) break;
            n++;
            chk({name, "_credit0"}, 32'(credit_cnt), 32'h0);
            tick();
        end
        chk({name, "_len"}, 32'(n), 32'(TRAIN));
        chk({name, "_up"}, 32'(tx_link_up), 32'h1);
        chk({name, "_credit"}, 32'(credit_cnt), 32'(CMAX));
        chk({name, "_idle"}, 32'(txdata_out), 32'h0);
    endtask

    initial begin
        logic [15:0] exp_w [2];
        int guard;
`ifdef FSIC_TX_PARITY_EN
        exp_w[0] = 16'hA123;
`else
        exp_w[0] = 16'h2123;
`endif
        exp_w[1] = 16'h4456;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", 32'(txdata_out), 32'h0);
        rst = 1'b0;
        tick();
        count_train("boot");

        // Alternating grants until credit runs out.
        src_data  = {12'h000, 12'h456, 12'h123};
        src_valid = 3'b011;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("alt_word", 32'(txdata_out), 32'(exp_w[i % 2]));
        end
        chk("alt_credit", 32'(credit_cnt), 32'h0);
        tick();
        chk("alt_stall", 32'(txdata_out), 32'h0);
        src_valid = 3'b000;

        for (int i = 0; i < 10; i++) begin
            credit_return = 1'b1;
            tick();
        end
        credit_return = 1'b0;
        chk("sat_credit", 32'(credit_cnt), 32'(CMAX));
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        chk("sat_hold", 32'(credit_cnt), 32'(CMAX));

        // Priority of requester 2 with rr_ptr at 1.
        src_valid = 3'b001;
        tick();
        src_valid = 3'b111;
        #1;
        chk("prio_ready2", 32'(src_ready), 32'h4);
        tick();
        src_valid = 3'b011;
        #1;
        chk("prio_ready0", 32'(src_ready), 32'h1);
        tick();
        src_valid = 3'b000;

        guard = 0;
        while (credit_cnt != 4'd3 && guard < 20) begin
            src_valid = 3'b001;
            tick();
            guard++;
        end
        chk("reach3", 32'(credit_cnt), 32'h3);
        src_data  = {12'h000, 12'h000, 12'h001};
        src_valid = 3'b001;
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        src_valid = 3'b000;
        chk("grant_ret_credit", 32'(credit_cnt), 32'h3);
        chk("grant_ret_word", 32'(txdata_out), 32'h2001);

        // Retrain while a requester is waiting.
        src_valid = 3'b001;
        retrain   = 1'b1;
        #1;
        chk("retrain_ready", 32'(src_ready), 32'h0);
        tick();
        retrain = 1'b0;
        count_train("retrain");
        src_valid = 3'b000;

        // Randomized traffic with occasional retrain and asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            src_valid     = 3'($urandom);
            src_data      = {4'($urandom), 32'($urandom)};
            credit_return = ($urandom % 3) == 0;
            retrain       = ($urandom % 60) == 0;
            if (($urandom % 500) == 0) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        retrain = 1'b0;
        src_valid = 3'b000;
        credit_return = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fsic_io_serdes_tx_sched.md
FSIC_IO_SERDES_TX_SCHED -- requirements
Module: fsic_io_serdes_tx_sched

Interface
REQ-001 SHALL have parameter pTRAIN_CYCLES, default 16, meaning number of training words sent before link-up (range 1..255).
REQ-002 SHALL have parameter pCREDIT_MAX, default 8, meaning remote receive-buffer credits granted after training (range 1..15).
REQ-003 SHALL have port coreclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port axis_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port retrain  input  1  single-cycle request to restart link training.
REQ-006 SHALL have port src_valid  input  3  per-requester word valid (0 = stream, 1 = mailbox, 2 = interrupt).
REQ-007 SHALL have port src_data  input  36  per-requester 12-bit payload, requester i at bits [12*i+11:12*i].
REQ-008 SHALL have port src_ready  output  3  per-requester accept; at most one bit high per cycle.
REQ-009 SHALL have port credit_return  input  1  one-cycle pulse returning one credit from the far end.
REQ-010 SHALL have port txdata_out  output  16  registered word for the serdes TX lanes (4 lanes x 4 bits).
REQ-011 SHALL have port tx_link_up  output  1  high while in ACTIVE.
REQ-012 SHALL have port credit_cnt  output  4  current credit count.

Function
REQ-013 SHALL implement FSM states IDLE, TRAIN, ACTIVE; IDLE -> TRAIN on the first cycle after reset release.
REQ-014 In TRAIN, SHALL drive txdata_out = 0xA5A5 for exactly pTRAIN_CYCLES cycles, then enter ACTIVE with credit_cnt = pCREDIT_MAX.
REQ-015 In ACTIVE, SHALL set tx_link_up = 1; in IDLE/TRAIN tx_link_up = 0 and src_ready = 0.
REQ-016 Data word format SHALL be [15] parity (see Configuration), [14:13] tag = requester index + 1, [12] = 0, [11:0] payload.
REQ-017 Idle word (no grant in ACTIVE) SHALL be 0x0000.
REQ-018 src_ready[i] SHALL be combinational: ACTIVE, credit_cnt > 0, src_valid[i] = 1 and i wins arbitration.
REQ-019 Arbitration SHALL be round-robin over valid requesters starting at rr_ptr; after a grant to i, rr_ptr <= (i+1) mod 3; rr_ptr unchanged when no grant.
REQ-020 Requester 2 SHALL win over round-robin whenever src_valid[2] = 1; rr_ptr still updates to 0 after such a grant.
REQ-021 Accepted word SHALL appear on txdata_out on the next rising edge (latency 1) and hold for one cycle only.
REQ-022 Each grant SHALL decrement credit_cnt; each credit_return SHALL increment it; both in one cycle SHALL leave it unchanged.
REQ-023 credit_cnt SHALL saturate at pCREDIT_MAX (extra returns ignored) and never underflow (no grant at 0).
REQ-024 credit_return outside ACTIVE SHALL be ignored.
REQ-025 retrain in any state SHALL move to TRAIN next cycle, restart the training count, force credit_cnt = 0 until re-entering ACTIVE, and suppress any grant in that cycle.
REQ-026 retrain asserted during TRAIN SHALL restart the full pTRAIN_CYCLES sequence.

Reset
REQ-027 On axis_rst SHALL set state IDLE, txdata_out = 0x0000, credit_cnt = 0, rr_ptr = 0, training count 0, tx_link_up = 0, src_ready = 0.
REQ-028 Reset assertion mid-word SHALL discard the word immediately; no partial state survives.

Configuration
REQ-029 With macro FSIC_TX_PARITY_EN defined, bit [15] of data words SHALL be even parity over bits [14:0] (XOR of [14:0]).
REQ-030 Without FSIC_TX_PARITY_EN, bit [15] SHALL be 0; training and idle words are unaffected in both builds.

Verification
REQ-031 Release reset, no traffic, pTRAIN_CYCLES = 16 -> 16 cycles of 0xA5A5, then tx_link_up = 1, credit_cnt = 8, txdata_out = 0x0000.
REQ-032 In ACTIVE, src_valid = 3'b011 held, payloads 0x123/0x456, no credit_return -> alternating grants 0,1,0,1..., words 0x2123 / 0x4456 (parity off), stop after 8 grants with credit_cnt = 0.
REQ-033 src_valid = 3'b111 with rr_ptr = 1 -> requester 2 granted, next cycle (src_valid[2] dropped) requester 0 granted.
REQ-034 credit_cnt = 8, credit_return pulse with no grant -> stays 8; credit_cnt = 3 with grant and credit_return same cycle -> stays 3.
REQ-035 retrain pulse in ACTIVE with src_valid[0] = 1 -> src_ready = 0 that cycle, 16 words 0xA5A5, credit_cnt = 0 during TRAIN, then 8.
REQ-036 FSIC_TX_PARITY_EN build, requester 0 payload 0x001 -> txdata_out = 0x2001 with bit 15 = 0 (two ones); payload 0x003 -> 0xA003.
